// File: rtl/spi_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_regs_pkg
// Purpose  : Register map, STATUS bit positions and FSM states shared by the
//            SPI master/slave register-port controllers.
// Revision : 1.0 - initial release
// ============================================================================
package spi_regs_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;
    localparam logic [2:0] ADDR_SSMASK  = 3'd5;

    localparam int STAT_RRDY = 6;
    localparam int STAT_TRDY = 5;
    localparam int STAT_ROE  = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CFG      = 3'd1,
        ST_PRE_POLL = 3'd2,
        ST_PRE_WR   = 3'd3,
        ST_RX_POLL  = 3'd4,
        ST_RX_READ  = 3'd5,
        ST_TX_WR    = 3'd6,
        ST_STOP     = 3'd7
    } ctrl_state_t;

    // Every non-idle state performs exactly one register access of this kind.
    function automatic logic is_write_state(ctrl_state_t s);
        return (s == ST_CFG) || (s == ST_PRE_WR) || (s == ST_TX_WR) || (s == ST_STOP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_control_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_control_if
// Purpose  : Register-port bus between the controller and the SPI slave core.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_slave_control_if
    import spi_regs_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();
    logic                  I_TX_EN;
    logic [2:0]            I_WADDR;
    logic [DATA_WIDTH-1:0] I_WDATA;
    logic                  I_RX_EN;
    logic [2:0]            I_RADDR;
    logic [DATA_WIDTH-1:0] O_RDATA;

    modport master (
        output I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR,
        input  O_RDATA
    );

    modport slave (
        input  I_TX_EN, I_WADDR, I_WDATA, I_RX_EN, I_RADDR,
        output O_RDATA
    );
endinterface
`default_nettype wire

// File: rtl/spi_reg_access.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_access
// Purpose  : Runs one 2-cycle register write or 4-cycle register read per req.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_access
    import spi_regs_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  wire logic                  I_CLK,
    input  wire logic                  I_RESET,
    input  wire logic                  req,
    input  wire logic                  we,
    input  wire logic [2:0]            addr,
    input  wire logic [DATA_WIDTH-1:0] wdata,
    output logic                       done,
    output logic [DATA_WIDTH-1:0]      rdata,
    spi_slave_control_if.master        bus
);

    logic       r_busy;
    logic       r_is_wr;
    logic [1:0] r_phase;

    // req is issued the cycle before c0, so the strobe register lands on c0.
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_busy      <= 1'b0;
            r_is_wr     <= 1'b0;
            r_phase     <= 2'd0;
            rdata       <= '0;
            bus.I_TX_EN <= 1'b0;
            bus.I_RX_EN <= 1'b0;
            bus.I_WADDR <= 3'd0;
            bus.I_WDATA <= '0;
            bus.I_RADDR <= 3'd0;
        end else begin
            bus.I_TX_EN <= req & we;
            bus.I_RX_EN <= req & ~we;
            if (req) begin
                r_busy  <= 1'b1;
                r_is_wr <= we;
                r_phase <= 2'd0;
                if (we) begin
                    bus.I_WADDR <= addr;
                    bus.I_WDATA <= wdata;
                end else begin
                    bus.I_RADDR <= addr;
                end
            end else if (r_busy) begin
                r_phase <= r_phase + 2'd1;
                if (done) begin
                    r_busy <= 1'b0;
                end
            end
            if (r_busy && !r_is_wr && (r_phase == 2'd2)) begin
                rdata <= bus.O_RDATA;
            end
        end
    end

    assign done = r_busy && (r_is_wr ? (r_phase == 2'd1) : (r_phase == 2'd3));

endmodule
`default_nettype wire

// File: rtl/spi_slave_control.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_control
// Purpose  : Configures the SPI slave core, then polls, checks and echoes bytes.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_control
    import spi_regs_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] CTRL_VALUE  = 8'h0B,
    parameter logic [DATA_WIDTH-1:0] IDLE_BYTE   = 8'hA5,
    parameter logic [DATA_WIDTH-1:0] EXPECT_BYTE = 8'h55,
    parameter bit                    ECHO        = 1'b1
) (
    input  wire logic                  I_CLK,
    input  wire logic                  I_RESET,
    input  wire logic                  start,
    spi_slave_control_if.master        bus,
    output logic [DATA_WIDTH-1:0]      rx_byte,
    output logic                       rx_valid,
    output logic                       err_flag,
    output logic                       ovr_flag,
    output logic [15:0]                rx_count
);

    ctrl_state_t           r_state;
    ctrl_state_t           w_next_state;
    logic                  r_start_dl;
    logic                  r_first_pend;
    logic                  w_accept;
    logic                  w_req;
    logic                  w_we;
    logic [2:0]            w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_set_ovr;
    logic                  w_take;

    assign w_accept = (r_state == ST_IDLE) && start && !r_start_dl;

    spi_reg_access #(.DATA_WIDTH(DATA_WIDTH)) u_access (
        .I_CLK   (I_CLK),
        .I_RESET (I_RESET),
        .req     (w_req),
        .we      (w_we),
        .addr    (w_addr),
        .wdata   (w_wdata),
        .done    (w_done),
        .rdata   (w_rdata),
        .bus     (bus)
    );

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_set_ovr    = 1'b0;
        w_take       = 1'b0;
        unique case (r_state)
            ST_IDLE:     if (w_accept) w_next_state = ST_CFG;
            ST_CFG:      if (w_done) w_next_state = ST_PRE_POLL;
            ST_PRE_POLL: if (w_done && w_rdata[STAT_TRDY]) w_next_state = ST_PRE_WR;
            ST_PRE_WR:   if (w_done) w_next_state = ST_RX_POLL;
            ST_RX_POLL: begin
                // A pending byte always wins over a stop request.
                if (w_done) begin
                    w_set_ovr = w_rdata[STAT_ROE];
                    if (w_rdata[STAT_RRDY]) begin
                        w_next_state = ST_RX_READ;
                    end else if (!start) begin
                        w_next_state = ST_STOP;
                    end
                end
            end
            ST_RX_READ: begin
                if (w_done) begin
                    w_take       = 1'b1;
                    w_next_state = ST_TX_WR;
                end
            end
            ST_TX_WR:    if (w_done) w_next_state = ST_RX_POLL;
            ST_STOP:     if (w_done) w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase

        w_req   = (w_next_state != ST_IDLE) && ((r_state == ST_IDLE) || w_done);
        w_we    = is_write_state(w_next_state);
        w_addr  = ADDR_STATUS;
        w_wdata = '0;
        case (w_next_state)
            ST_CFG: begin
                w_addr  = ADDR_CONTROL;
                w_wdata = CTRL_VALUE;
            end
            ST_PRE_WR: begin
                w_addr  = ADDR_TXDATA;
                w_wdata = IDLE_BYTE;
            end
            ST_RX_READ: w_addr = ADDR_RXDATA;
            // TX_WR is only entered from RX_READ, so w_rdata is the new byte.
            ST_TX_WR: begin
                w_addr  = ADDR_TXDATA;
                w_wdata = ECHO ? w_rdata : IDLE_BYTE;
            end
            ST_STOP: begin
                w_addr  = ADDR_CONTROL;
                w_wdata = '0;
            end
            default: w_addr = ADDR_STATUS;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_start_dl   <= 1'b0;
            r_first_pend <= 1'b0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            err_flag     <= 1'b0;
            ovr_flag     <= 1'b0;
            rx_count     <= 16'd0;
        end else begin
            r_start_dl <= start;
            rx_valid   <= w_take;
            if (w_accept) begin
                err_flag     <= 1'b0;
                ovr_flag     <= 1'b0;
                rx_count     <= 16'd0;
                r_first_pend <= 1'b1;
            end else begin
                if (w_set_ovr) begin
                    ovr_flag <= 1'b1;
                end
                if (w_take) begin
                    rx_byte      <= w_rdata;
                    rx_count     <= rx_count + 16'd1;
                    err_flag     <= r_first_pend ? 1'b0 : (w_rdata != EXPECT_BYTE);
                    r_first_pend <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_control
// Purpose  : Directed bench with a slave-core register model; a second ECHO=0
//            instance shadows the first on the same read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_control;
    import spi_regs_pkg::*;

    logic clk;
    logic rst;
    logic start;

    spi_slave_control_if #(.DATA_WIDTH(8)) bus_a ();
    spi_slave_control_if #(.DATA_WIDTH(8)) bus_b ();

    logic [7:0]  rx_byte_a, rx_byte_b;
    logic        rx_valid_a, rx_valid_b;
    logic        err_a, err_b;
    logic        ovr_a, ovr_b;
    logic [15:0] cnt_a, cnt_b;

    spi_slave_control #(.ECHO(1'b1)) dut_a (
        .I_CLK(clk), .I_RESET(rst), .start(start), .bus(bus_a),
        .rx_byte(rx_byte_a), .rx_valid(rx_valid_a), .err_flag(err_a),
        .ovr_flag(ovr_a), .rx_count(cnt_a)
    );

    spi_slave_control #(.ECHO(1'b0)) dut_b (
        .I_CLK(clk), .I_RESET(rst), .start(start), .bus(bus_b),
        .rx_byte(rx_byte_b), .rx_valid(rx_valid_b), .err_flag(err_b),
        .ovr_flag(ovr_b), .rx_count(cnt_b)
    );

    assign bus_b.O_RDATA = bus_a.O_RDATA;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave-core model state: producer side written by the stimulus only
    logic       trdy;
    logic       roe;
    logic [7:0] rx_mem [0:31];
    int         wr_ptr;
    // Model side written by the model process only
    int         rd_ptr;
    int         rd_count;
    int         rrdy_cnt;
    int         wa_n, wb_n;
    logic [2:0] wa_addr [0:127];
    logic [7:0] wa_data [0:127];
    logic [2:0] wb_addr [0:127];
    logic [7:0] wb_data [0:127];
    int         ovl_cnt, wide_cnt;
    logic       prev_tx, prev_rx;
    logic [7:0] pipe_d;
    logic [7:0] resp;

    initial begin
        rd_ptr = 0; rd_count = 0; rrdy_cnt = 0; wa_n = 0; wb_n = 0;
        ovl_cnt = 0; wide_cnt = 0; prev_tx = 1'b0; prev_rx = 1'b0;
        pipe_d = 8'h00; bus_a.O_RDATA = 8'h00;
    end

    always @(posedge clk) begin
        if (bus_a.I_TX_EN && bus_a.I_RX_EN) ovl_cnt++;
        if ((bus_a.I_TX_EN && prev_tx) || (bus_a.I_RX_EN && prev_rx)) wide_cnt++;
        prev_tx = bus_a.I_TX_EN;
        prev_rx = bus_a.I_RX_EN;
        if (bus_a.I_TX_EN && wa_n < 128) begin
            wa_addr[wa_n] = bus_a.I_WADDR; wa_data[wa_n] = bus_a.I_WDATA; wa_n++;
        end
        if (bus_b.I_TX_EN && wb_n < 128) begin
            wb_addr[wb_n] = bus_b.I_WADDR; wb_data[wb_n] = bus_b.I_WDATA; wb_n++;
        end
        if (bus_a.I_RX_EN) begin
            rd_count++;
            resp = 8'h00;
            if (bus_a.I_RADDR == ADDR_STATUS) begin
                resp[6] = (wr_ptr != rd_ptr);
                resp[5] = trdy;
                resp[3] = roe;
                if (resp[6]) rrdy_cnt++;
            end else if (bus_a.I_RADDR == ADDR_RXDATA && wr_ptr != rd_ptr) begin
                resp = rx_mem[rd_ptr % 32];
                rd_ptr++;
            end
            pipe_d <= resp;
        end
        bus_a.O_RDATA <= pipe_d;
    end

    int total, bad;
    int wa_i, wb_i;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {bus_a.I_TX_EN, bus_a.I_RX_EN, bus_a.I_WADDR, bus_a.I_RADDR,
                bus_a.I_WDATA, rx_valid_a, err_a, ovr_a, (rx_byte_a != 8'h00),
                (cnt_a != 16'd0), (bus_a.I_WDATA != 8'h00)};
    endfunction

    task automatic expect_write(input string nm, input logic [2:0] a, input logic [7:0] d);
        int n;
        logic [7:0] db;
        n = 0;
        while ((wa_i >= wa_n || wb_i >= wb_n) && n < 200) begin
            @(negedge clk); n++;
        end
        if (wa_i >= wa_n || wb_i >= wb_n) begin
            check({nm, "_timeout"}, 32'd0, 32'd1);
        end else begin
            db = (a == ADDR_TXDATA) ? 8'hA5 : d;
            check(nm, {21'd0, wa_addr[wa_i], wa_data[wa_i]}, {21'd0, a, d});
            check({nm, "_noecho"}, {21'd0, wb_addr[wb_i], wb_data[wb_i]}, {21'd0, a, db});
            wa_i++; wb_i++;
        end
    endtask

    task automatic wait_rxv(input string nm);
        int n;
        n = 0;
        while (!rx_valid_a && n < 100) begin
            @(negedge clk); n++;
        end
        if (!rx_valid_a) check({nm, "_rxv_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_mem[wr_ptr % 32] = b;
        wr_ptr++;
    endtask

    task automatic quiet(input string nm);
        int w0, r0;
        w0 = wa_n; r0 = rd_count;
        repeat (25) @(negedge clk);
        check({nm, "_no_wr"}, wa_n, w0);
        check({nm, "_no_rd"}, rd_count, r0);
    endtask

    typedef struct {
        logic [7:0]  din;
        logic        exp_err;
        logic [15:0] exp_cnt;
        logic [7:0]  exp_echo;
    } vec_t;

    vec_t vecs [0:3];

    initial begin
        int n;
        int snap;
        total = 0; bad = 0; wa_i = 0; wb_i = 0;
        wr_ptr = 0; trdy = 1'b0; roe = 1'b0;
        rst = 1'b1; start = 1'b0;

        vecs[0] = '{8'h55, 1'b0, 16'd1, 8'h55};
        vecs[1] = '{8'h55, 1'b0, 16'd2, 8'h55};
        vecs[2] = '{8'h12, 1'b1, 16'd3, 8'h12};
        vecs[3] = '{8'h77, 1'b1, 16'd4, 8'h77};

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 32'd0);
        rst = 1'b0;

        // Reset while a STATUS read is in flight (TRDY=0 keeps it polling)
        @(negedge clk); start = 1'b1;
        n = 0;
        while (!(bus_a.I_RX_EN && bus_a.I_RADDR == ADDR_STATUS) && n < 50) begin
            @(negedge clk); n++;
        end
        check("status_read_seen", {31'd0, bus_a.I_RX_EN}, 32'd1);
        @(posedge clk); #2;
        rst = 1'b1; start = 1'b0;
        #1;
        check("midread_reset_outputs", all_outs(), 32'd0);
        @(negedge clk); rst = 1'b0;
        quiet("after_reset");
        wa_i = wa_n; wb_i = wb_n;

        // Start with TRDY=1: CONTROL write must be the very next cycle
        trdy = 1'b1; start = 1'b1;
        snap = rd_count;
        @(posedge clk); #1;
        check("first_strobe", {21'd0, bus_a.I_TX_EN, bus_a.I_WADDR, bus_a.I_WDATA},
              {21'd0, 1'b1, ADDR_CONTROL, 8'h0B});
        expect_write("cfg_write", ADDR_CONTROL, 8'h0B);
        expect_write("preload", ADDR_TXDATA, 8'hA5);
        check("status_polled", {31'd0, rd_count > snap}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk); push_byte(vecs[i].din);
            wait_rxv($sformatf("v%0d", i));
            check($sformatf("v%0d_byte", i), {24'd0, rx_byte_a}, {24'd0, vecs[i].din});
            check($sformatf("v%0d_err", i), {31'd0, err_a}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d_cnt", i), {16'd0, cnt_a}, {16'd0, vecs[i].exp_cnt});
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), {31'd0, rx_valid_a}, 32'd0);
            expect_write($sformatf("v%0d_echo", i), ADDR_TXDATA, vecs[i].exp_echo);
        end

        // RRDY and ROE together: STATUS=0x48
        @(negedge clk); trdy = 1'b0; roe = 1'b1; push_byte(8'h55);
        wait_rxv("ovr");
        check("ovr_set", {31'd0, ovr_a}, 32'd1);
        check("ovr_byte", {24'd0, rx_byte_a}, 32'h55);
        check("ovr_cnt", {16'd0, cnt_a}, 32'd5);
        expect_write("ovr_echo", ADDR_TXDATA, 8'h55);
        roe = 1'b0;
        repeat (20) @(negedge clk);
        check("ovr_sticky", {31'd0, ovr_a}, 32'd1);

        // Stop requested while a byte is already pending
        snap = rrdy_cnt;
        @(negedge clk); push_byte(8'h12);
        n = 0;
        while (rrdy_cnt == snap && n < 50) begin
            @(negedge clk); n++;
        end
        start = 1'b0;
        wait_rxv("pend");
        check("pend_byte", {24'd0, rx_byte_a}, 32'h12);
        check("pend_cnt", {16'd0, cnt_a}, 32'd6);
        check("pend_err", {31'd0, err_a}, 32'd1);
        expect_write("pend_echo", ADDR_TXDATA, 8'h12);
        expect_write("pend_stop", ADDR_CONTROL, 8'h00);
        quiet("after_pend_stop");

        // Restart clears flags; first byte never flags an error
        @(negedge clk); trdy = 1'b1; start = 1'b1;
        @(negedge clk);
        check("restart_ovr_clr", {31'd0, ovr_a}, 32'd0);
        check("restart_err_clr", {31'd0, err_a}, 32'd0);
        check("restart_cnt_clr", {16'd0, cnt_a}, 32'd0);
        expect_write("restart_cfg", ADDR_CONTROL, 8'h0B);
        expect_write("restart_preload", ADDR_TXDATA, 8'hA5);
        @(negedge clk); push_byte(8'h33);
        wait_rxv("first");
        check("first_err", {31'd0, err_a}, 32'd0);
        check("first_cnt", {16'd0, cnt_a}, 32'd1);
        expect_write("first_echo", ADDR_TXDATA, 8'h33);

        // Stop while idle-polling: exactly one CONTROL=0 write
        @(negedge clk); start = 1'b0;
        expect_write("idle_stop", ADDR_CONTROL, 8'h00);
        quiet("after_idle_stop");
        check("no_extra_writes", wa_n, wa_i);

        check("strobe_overlap", ovl_cnt, 0);
        check("strobe_width", wide_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_control.md
Name: spi_slave_control

Overview:
- Drives the register interface of the SPI slave core. It is the far-end counterpart of spi_control, which drives the SPI master core.
- Configures the slave core, then preloads a TX byte.
- Loops: polls STATUS, reads each received byte, checks it against the expected pattern, and echoes it back into TXDATA so the master sees it on the next transfer.
- Sits between board-level start/LED logic and the slave core register port.

Parameters:
- DATA_WIDTH, 8, register data width.
- CTRL_VALUE, 8'h0B, value written to CONTROL when enabling the slave core.
- IDLE_BYTE, 8'hA5, byte preloaded into TXDATA before the first transfer, and used when ECHO=0.
- EXPECT_BYTE, 8'h55, pattern every received byte is compared against.
- ECHO, 1, 1 = write each received byte back to TXDATA; 0 = always write IDLE_BYTE.

Ports:
- I_CLK  in  1  system clock.
- I_RESET  in  1  asynchronous reset, active-high.
- start  in  1  rising edge starts the block; low level requests stop.
- I_TX_EN  out  1  register write strobe, one-cycle pulse.
- I_WADDR  out  3  register write address.
- I_WDATA  out  DATA_WIDTH  register write data.
- I_RX_EN  out  1  register read strobe, one-cycle pulse.
- I_RADDR  out  3  register read address.
- O_RDATA  in  DATA_WIDTH  register read data, valid 2 cycles after I_RX_EN.
- rx_byte  out  DATA_WIDTH  last received byte.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- err_flag  out  1  last checked byte != EXPECT_BYTE.
- ovr_flag  out  1  sticky overrun seen (STATUS[3]).
- rx_count  out  16  received-byte counter.

Behaviour:
- Register map: RXDATA=0, TXDATA=1, STATUS=2, CONTROL=3.
- STATUS bits: [6] RRDY, [5] TRDY, [3] ROE.
- Reset (async, I_RESET=1): all outputs 0, state IDLE, start_dl=0. Takes effect immediately, mid-transaction included; no bus cleanup is done.
- start_dl is registered start. A start edge is start=1 and start_dl=0.
- Write sequence (2 cycles):
  - c0: I_TX_EN=1 with I_WADDR/I_WDATA valid.
  - c1: I_TX_EN=0.
  - I_WADDR/I_WDATA hold their value until the next write.
- Read sequence (4 cycles):
  - c0: I_RX_EN=1 with I_RADDR.
  - c1: I_RX_EN=0.
  - c2: capture O_RDATA.
  - c3: decide.
- I_TX_EN and I_RX_EN are never high in the same cycle.
- FSM:
  - IDLE: strobes low. On a start edge, go to CFG; the first I_TX_EN is in the next cycle.
  - CFG: write CONTROL=CTRL_VALUE, then go to PRE_POLL.
  - PRE_POLL: read STATUS. If TRDY=1, go to PRE_WR; otherwise repeat.
  - PRE_WR: write TXDATA=IDLE_BYTE, then go to RX_POLL.
  - RX_POLL: read STATUS, then at c3:
    - If ROE=1, set ovr_flag.
    - Then, if RRDY=1, go to RX_READ.
    - Else, if start=0, go to STOP.
    - Else repeat.
    - ROE and RRDY set together: flag the overrun and still read.
  - RX_READ: read RXDATA. At c3:
    - rx_byte <= data and rx_valid=1 for one cycle.
    - rx_count increments, wrapping 16'hFFFF to 0.
    - First byte after a start edge: err_flag=0, since the master echo is not yet aligned.
    - Later bytes: err_flag <= (data != EXPECT_BYTE).
    - Go to TX_WR.
  - TX_WR: write TXDATA = ECHO ? rx_byte : IDLE_BYTE, then go to RX_POLL.
  - STOP: write CONTROL=8'h00, then go to IDLE.
- start behaviour outside RX_POLL:
  - Start edges outside IDLE are ignored.
  - start=0 is checked only in RX_POLL with RRDY=0, so a byte already received is always read and echoed before stopping.
- Flags:
  - ovr_flag clears only on a start edge or reset.
  - err_flag and rx_count clear on a start edge.
- Latency, RRDY set to echo write strobe: at most 4 (poll in flight) + 4 (poll) + 4 (read) + 1 = 13 cycles.

Decomposition:
- Shared package spi_regs_pkg holds:
  - register address constants (RXDATA/TXDATA/STATUS/CONTROL/SSMASK);
  - STATUS bit indices;
  - the DATA_WIDTH default;
  - the FSM state enumeration.
- spi_control uses the same package.
- One natural sub-module, spi_reg_access:
  - executes the 2-cycle write and 4-cycle read sequences;
  - handshake: req, we, addr, wdata in; done, rdata out.
- spi_slave_control keeps the top FSM, flags and counter.

Test Plan:
- Reset mid-read (assert I_RESET in c1 of a STATUS read):
  - all outputs read 0 in the same cycle;
  - after release, no strobe appears until a start edge.
- Start edge with the slave model at TRDY=1:
  - write CONTROL=0x0B;
  - STATUS read;
  - write TXDATA=0xA5;
  - all strobes exactly one cycle wide.
- Model delivers 0x55, 0x55, 0x12:
  - rx_valid three times;
  - rx_count=3;
  - err_flag 0, 0, 1;
  - three TXDATA writes of 0x55, 0x55, 0x12.
- STATUS=0x48 (RRDY+ROE):
  - ovr_flag=1 and stays 1;
  - byte still read;
  - the next start edge clears ovr_flag.
- start low while idle-polling:
  - exactly one write CONTROL=0x00, then IDLE.
- start low with RRDY=1 pending:
  - the byte is read and echoed first, then the stop write.
- ECHO=0:
  - every TXDATA write is 0xA5 regardless of the received byte.
